// File: rtl/huff_chunk_feeder.sv
// Slices an MSB-aligned encoded block into chunks of up to 4 bits and strobes each chunk to the
// Huffman decoder. Each chunk takes one setup cycle, VALID_CYCLES cycles of sValid, then GAP_CYCLES idle cycles.
module huff_chunk_feeder #(
  parameter int BLK_BITS     = 256,
  parameter int VALID_CYCLES = 2,
  parameter int GAP_CYCLES   = 16,
  parameter int LEN_W        = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [BLK_BITS-1:0] blk_data,
  input  logic [LEN_W-1:0]    blk_len,
  output logic                sValid,
  output logic [3:0]          in_bits,
  output logic [2:0]          in_len,
  output logic                busy,
  output logic                done,
  output logic [6:0]          chunks_sent,
  output logic [LEN_W-1:0]    bits_left
);

  localparam int CNT_MAX = (VALID_CYCLES > GAP_CYCLES) ? VALID_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, SETUP, SEND, GAP} state_t;

  state_t              state_reg, state_next;
  logic [BLK_BITS-1:0] buf_reg, buf_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                sv_reg, sv_next;
  logic [3:0]          bits_reg, bits_next;
  logic [2:0]          len_reg, len_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic [6:0]          sent_reg, sent_next;
  logic [LEN_W-1:0]    left_reg, left_next;

  logic [LEN_W-1:0]    len_clamped;
  logic [BLK_BITS-1:0] src_data;
  logic [LEN_W-1:0]    src_len;
  logic [2:0]          take;
  logic [3:0]          top4;
  logic                load;

  // The first chunk comes straight from the input port; later ones come from the shifted buffer.
  assign len_clamped = (blk_len > LEN_W'(BLK_BITS)) ? LEN_W'(BLK_BITS) : blk_len;
  assign src_data    = (state_reg == IDLE) ? blk_data : buf_reg;
  assign src_len     = (state_reg == IDLE) ? len_clamped : left_reg;
  assign take        = (src_len >= LEN_W'(4)) ? 3'd4 : src_len[2:0];
  assign top4        = src_data[BLK_BITS-1 -: 4];

  always_comb begin
    state_next = state_reg;
    buf_next   = buf_reg;
    cnt_next   = cnt_reg;
    sv_next    = sv_reg;
    bits_next  = bits_reg;
    len_next   = len_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    sent_next  = sent_reg;
    left_next  = left_reg;
    load       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (len_clamped == '0) begin
            done_next = 1'b1;
          end else begin
            load      = 1'b1;
            sent_next = '0;
            busy_next = 1'b1;
          end
        end
      end
      SETUP: begin
        sv_next    = 1'b1;
        sent_next  = sent_reg + 7'd1;
        cnt_next   = '0;
        state_next = SEND;
      end
      SEND: begin
        if (cnt_reg == CNT_W'(VALID_CYCLES - 1)) begin
          sv_next    = 1'b0;
          cnt_next   = '0;
          state_next = GAP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_reg == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_next = '0;
          if (left_reg == '0) begin
            state_next = IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            load = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // A short final chunk keeps only its top bits, right-aligned.
    if (load) begin
      buf_next   = src_data << take;
      bits_next  = top4 >> (3'd4 - take);
      len_next   = take;
      left_next  = src_len - LEN_W'(take);
      state_next = SETUP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      buf_reg   <= '0;
      cnt_reg   <= '0;
      sv_reg    <= 1'b0;
      bits_reg  <= '0;
      len_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      sent_reg  <= '0;
      left_reg  <= '0;
    end else begin
      state_reg <= state_next;
      buf_reg   <= buf_next;
      cnt_reg   <= cnt_next;
      sv_reg    <= sv_next;
      bits_reg  <= bits_next;
      len_reg   <= len_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      sent_reg  <= sent_next;
      left_reg  <= left_next;
    end
  end

  assign sValid      = sv_reg;
  assign in_bits     = bits_reg;
  assign in_len      = len_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign chunks_sent = sent_reg;
  assign bits_left   = left_reg;

endmodule

// File: tb/tb_huff_chunk_feeder.sv
// Scoreboard bench for huff_chunk_feeder: the driver queues expected chunks and done pulses
// from a bit-list model; a negedge monitor pops and compares whenever the DUT strobes.
module tb_huff_chunk_feeder;

  localparam int BLK    = 256;
  localparam int VALID  = 2;
  localparam int GAPC   = 16;
  localparam int PERIOD = 1 + VALID + GAPC;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [BLK-1:0] blk_data = '0;
  logic [8:0]     blk_len = '0;
  logic           sValid;
  logic [3:0]     in_bits;
  logic [2:0]     in_len;
  logic           busy;
  logic           done;
  logic [6:0]     chunks_sent;
  logic [8:0]     bits_left;

  huff_chunk_feeder #(.BLK_BITS(BLK), .VALID_CYCLES(VALID), .GAP_CYCLES(GAPC), .LEN_W(9)) dut (
    .clk(clk), .reset(reset), .start(start), .blk_data(blk_data), .blk_len(blk_len),
    .sValid(sValid), .in_bits(in_bits), .in_len(in_len), .busy(busy), .done(done),
    .chunks_sent(chunks_sent), .bits_left(bits_left)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {int bits; int len; int left; int idx; int cyc;} chunk_t;
  typedef struct {int cyc; int n;} done_t;
  chunk_t exp_q[$];
  done_t  done_q[$];

  int checks = 0;
  int errors = 0;

  // Reference: walk the block as a list of bits, four at a time, MSB first.
  task automatic issue_block(input logic [BLK-1:0] data, input int len_in, output int s);
    int L, n, pos, ln, v;
    L = (len_in > BLK) ? BLK : len_in;
    n = (L + 3) / 4;
    @(posedge clk); #1;
    start = 1'b1; blk_data = data; blk_len = 9'(len_in);
    s = cyc + 1;
    for (int k = 0; k < n; k++) begin
      pos = 4 * k;
      ln  = (L - pos < 4) ? (L - pos) : 4;
      v   = 0;
      for (int j = 0; j < ln; j++) v = v * 2 + int'(data[BLK-1-pos-j]);
      exp_q.push_back('{v, ln, L - pos - ln, k, s + 1 + PERIOD * k});
    end
    done_q.push_back('{s + PERIOD * n, n});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_q.size() != 0; i++) @(posedge clk);
    if (done_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout: %0d done pulses and %0d chunks still pending at cycle %0d",
               done_q.size(), exp_q.size(), cyc);
      done_q.delete(); exp_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  function automatic logic [BLK-1:0] rand_block();
    logic [BLK-1:0] d;
    for (int i = 0; i < BLK / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Monitor
  logic       prev_sv = 1'b0;
  logic [3:0] prev_bits = '0;
  logic [2:0] prev_len = '0;
  logic       have_cur = 1'b0;
  int         cur_rise = 0, cur_bits = 0, cur_len = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_sv = 1'b0; have_cur = 1'b0;
    end else begin
      if (sValid && !prev_sv) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_chunk: in_bits=%h in_len=%0d at cycle %0d, none expected", in_bits, in_len, cyc);
        end else begin
          chunk_t e;
          e = exp_q.pop_front();
          if (in_bits !== 4'(e.bits) || in_len !== 3'(e.len) || bits_left !== 9'(e.left) ||
              chunks_sent !== 7'(e.idx + 1) || cyc != e.cyc ||
              prev_bits !== 4'(e.bits) || prev_len !== 3'(e.len)) begin
            errors++;
            $display("FAIL chunk%0d: got bits=%h len=%0d left=%0d sent=%0d cyc=%0d setup=%h/%0d, want bits=%h len=%0d left=%0d sent=%0d cyc=%0d",
                     e.idx, in_bits, in_len, bits_left, chunks_sent, cyc, prev_bits, prev_len,
                     e.bits, e.len, e.left, e.idx + 1, e.cyc);
          end
          have_cur = 1'b1; cur_rise = cyc; cur_bits = e.bits; cur_len = e.len;
        end
      end
      if (!sValid && prev_sv) begin
        checks++;
        if (cyc - cur_rise != VALID) begin
          errors++;
          $display("FAIL svalid_width: got %0d cycles, want %0d", cyc - cur_rise, VALID);
        end
      end
      if (have_cur && cyc > cur_rise && cyc <= cur_rise + PERIOD - 2) begin
        checks++;
        if (in_bits !== 4'(cur_bits) || in_len !== 3'(cur_len)) begin
          errors++;
          $display("FAIL stable: cycle %0d got %h/%0d, want %h/%0d", cyc, in_bits, in_len, cur_bits, cur_len);
        end
      end
      if (done) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: at cycle %0d", cyc);
        end else begin
          done_t d;
          d = done_q.pop_front();
          if (cyc != d.cyc || busy !== 1'b0 || (d.n > 0 && chunks_sent !== 7'(d.n))) begin
            errors++;
            $display("FAIL done: got cyc=%0d busy=%b sent=%0d, want cyc=%0d busy=0 sent=%0d",
                     cyc, busy, chunks_sent, d.cyc, d.n);
          end
          have_cur = 1'b0;
        end
      end
      prev_sv = sValid; prev_bits = in_bits; prev_len = in_len;
    end
  end

  initial begin
    int s;
    logic [BLK-1:0] d;
    bit bad;

    repeat (2) @(posedge clk); #1;
    checks++;
    if ({sValid, in_bits, in_len, busy, done, chunks_sent, bits_left} !== '0) begin
      errors++;
      $display("FAIL reset_state: sv=%b bits=%h len=%0d busy=%b done=%b sent=%0d left=%0d, want all 0",
               sValid, in_bits, in_len, busy, done, chunks_sent, bits_left);
    end
    reset = 1'b0;

    // Full 256-bit block
    issue_block(rand_block(), 256, s);
    $display("block len=256 start_edge=%0d", s);
    wait_done(PERIOD * 70);

    // Short block 1011_0010_01
    d = '0; d[BLK-1 -: 10] = 10'b1011001001;
    issue_block(d, 10, s);
    $display("block len=10 start_edge=%0d", s);
    wait_done(PERIOD * 5);

    // Zero-length block: done only, no busy, no strobe
    issue_block(rand_block(), 0, s);
    $display("block len=0 start_edge=%0d", s);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy !== 1'b0 || sValid !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL zero_len: busy or sValid went high, want both 0");
    end
    wait_done(10);

    // Over-length block clamps to 256
    issue_block(rand_block(), 300, s);
    $display("block len=300 start_edge=%0d", s);
    wait_done(PERIOD * 70);

    // Start while busy is ignored
    issue_block(rand_block(), 256, s);
    while (cyc < s + 1 + PERIOD * 2 + 3) begin @(posedge clk); #1; end
    start = 1'b1; blk_len = 9'd4; blk_data = rand_block();
    @(posedge clk); #1;
    start = 1'b0;
    $display("block len=256 start_edge=%0d with ignored restart", s);
    wait_done(PERIOD * 70);

    // Asynchronous reset during SEND of chunk 5
    issue_block(rand_block(), 256, s);
    while (cyc < s + 1 + PERIOD * 4) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    exp_q.delete(); done_q.delete();
    #1;
    checks++;
    if (sValid !== 1'b0 || busy !== 1'b0 || in_bits !== 4'd0 || chunks_sent !== 7'd0) begin
      errors++;
      $display("FAIL async_reset: sv=%b busy=%b bits=%h sent=%0d, want all 0", sValid, busy, in_bits, chunks_sent);
    end
    $display("reset asserted mid-send at cycle %0d", cyc);
    @(posedge clk); #1;
    reset = 1'b0;
    d = '0; d[BLK-1 -: 3] = 3'b101;
    issue_block(d, 3, s);
    $display("block len=3 start_edge=%0d after reset", s);
    wait_done(PERIOD * 3);

    // Random lengths and data
    for (int t = 0; t < 4; t++) begin
      int ln;
      ln = $urandom_range(1, 256);
      issue_block(rand_block(), ln, s);
      $display("block len=%0d start_edge=%0d random", ln, s);
      wait_done(PERIOD * 70);
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d chunks never strobed, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/huff_chunk_feeder.md
Name: huff_chunk_feeder

Overview:
- Upstream stage of the Huffman decoder (`shift_reg`).
- Accepts one MSB-aligned encoded block of up to BLK_BITS bits.
- Slices the block MSB-first into chunks of up to 4 bits and presents each chunk on in_bits/in_len with a timed sValid pulse.
- Chunk pacing matches the decoder's intake rate: bits are set up one cycle ahead, sValid is held VALID_CYCLES, then the feeder idles GAP_CYCLES.

Parameters:
- BLK_BITS, 256, block buffer width in bits; a multiple of 4.
- VALID_CYCLES, 2, cycles sValid is held high per chunk; must be ≥1.
- GAP_CYCLES, 16, idle cycles after sValid falls, before the next chunk; must be ≥1.
- LEN_W, 9, width of blk_len and bits_left; equals $clog2(BLK_BITS+1).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high; clears all state.
- start, input, 1, single-cycle request to load a block; sampled only in IDLE.
- blk_data, input, BLK_BITS, encoded bits, MSB-aligned (first bit at BLK_BITS-1).
- blk_len, input, LEN_W, number of valid bits in blk_data; values above BLK_BITS are clamped to BLK_BITS.
- sValid, output, 1, chunk strobe to the decoder.
- in_bits, output, 4, current chunk, right-aligned, unused upper bits 0.
- in_len, output, 3, current chunk length, 1..4.
- busy, output, 1, high from the start acceptance edge until done.
- done, output, 1, one-cycle pulse after the last chunk's gap completes.
- chunks_sent, output, 7, number of sValid rising edges issued for the current block.
- bits_left, output, LEN_W, bits not yet presented (excludes the current chunk).

Behaviour:
- Reset values: state=IDLE, sValid=0, in_bits=0, in_len=0, busy=0, done=0, chunks_sent=0, bits_left=0, buffer=0.
- FSM states: IDLE, SETUP, SEND, GAP.
- All outputs are registered.

IDLE:
- done=0 except for the single pulse cycle defined below.
- start=1 and clamped blk_len=0: done=1 for the next cycle only; busy stays 0; no chunk is issued.
- start=1 and clamped blk_len≥1, at that edge:
  - buffer ← blk_data shifted left by len;
  - len = min(4, blk_len);
  - in_bits ← top len bits of blk_data, right-aligned;
  - in_len ← len;
  - bits_left ← blk_len − len;
  - chunks_sent ← 0;
  - busy ← 1;
  - state → SETUP.

SETUP:
- Lasts exactly one cycle; sValid=0.
- Next edge: sValid ← 1, chunks_sent ← chunks_sent+1, state → SEND.

SEND:
- sValid stays high for exactly VALID_CYCLES cycles.
- Then sValid ← 0, state → GAP.

GAP:
- Lasts GAP_CYCLES cycles.
- At the final edge, if bits_left=0: state → IDLE, busy ← 0, done ← 1 for one cycle.
- Otherwise, load the next chunk the same way as at start, from the buffer and bits_left, then state → SETUP.

Output stability and timing:
- in_bits/in_len are stable from the load edge through the end of GAP.
- Per-chunk period is 1+VALID_CYCLES+GAP_CYCLES cycles (19 with defaults).
- Total block duration is N_chunks×period, with N_chunks = ceil(blk_len/4).

Boundary conditions:
- start while busy: ignored. No effect on the buffer, counters or outputs.
- Last chunk length: blk_len mod 4 when that is nonzero; otherwise 4.
- Reset mid-operation: asynchronous return to IDLE with all outputs at their reset values. A partially sent block is dropped and a new start is required.
- Counters are internal only: one for VALID_CYCLES/GAP_CYCLES, sized to max(VALID_CYCLES, GAP_CYCLES).

Test Plan:
1. Defaults; blk_len=256, blk_data arbitrary; start at cycle 0.
   - Required: exactly 64 sValid pulses, each 2 cycles wide, rising edges 19 cycles apart.
   - Every in_len=4; every in_bits equals the matching nibble, MSB-first.
   - done pulses once, 64×19=1216 cycles after the start edge; chunks_sent=64.
2. blk_len=10, blk_data top bits 1011_0010_01.
   - Required: chunks (1011,4), (0010,4), (0001,2).
   - bits_left after each load: 6, 2, 0; done after 57 cycles.
3. in_bits/in_len change observed relative to sValid.
   - Required: new values appear exactly one cycle before sValid rises.
   - Values are unchanged while sValid=1 and through GAP.
4. start with blk_len=0 → done=1 one cycle later; busy never high; sValid never high. start with blk_len=300 → treated as 256 (64 chunks).
5. Second start pulse with blk_len=4 during chunk 3 of a 256-bit block.
   - Required: ignored; the block still yields 64 chunks with unchanged data.
6. Reset asserted asynchronously mid-SEND of chunk 5.
   - Required: sValid, busy, in_bits, chunks_sent drop to 0 immediately.
   - After reset release, a new start with blk_len=3, data 101 → a single chunk (0101,3), then done.
